// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph constants,
// nibble-to-glyph lookup and the converter state encoding.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } conv_state_t;

    // Non-decimal nibbles never come out of the converter; show them dark.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_LOAD  | idle; on start latch bin, clear BCD shifter and overflow
// ST_SHIFT | BIN_W cycles of add-3 then shift-left; carry-out sets ovf
// ST_WRITE | done pulse; bcd/ovf hold the finished result
module bin2bcd_seq #(
    parameter int BIN_W      = 9,
    parameter int DIG_PER_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIG_PER_CH-1:0] bcd,
    output logic                    ovf
);
    import seg7_pkg::*;

    localparam int BCD_W = 4 * DIG_PER_CH;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t      state_q, state_d;
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    // Add 3 to every nibble of 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIG_PER_CH; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; shift phase ends on terminal count 1.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                done    = 1'b1;
                state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Datapath: latch, shift with sticky overflow, down-count remaining bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == ST_LOAD && start) begin
            bin_q <= bin;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= CNT_W'(BIN_W);
        end else if (state_q == ST_SHIFT) begin
            bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            ovf_q <= ovf_q | bcd_adj[BCD_W-1];
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bcd = bcd_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-channel 7-segment scan driver: round-robin BCD conversion of each
// score, per-channel display registers and a multiplexed active-low bus.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan_driver #(
    parameter int NUM_CH      = 2,
    parameter int DIG_PER_CH  = 4,
    parameter int BIN_W       = 9,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*BIN_W-1:0]        score_i,
    input  logic [NUM_CH*DIG_PER_CH-1:0]   digit_en_i,
    output logic [NUM_CH*DIG_PER_CH-1:0]   anode,
    output logic [6:0]                     segment,
    output logic                           frame_o
);
    import seg7_pkg::*;

    localparam int ND    = NUM_CH * DIG_PER_CH;
    localparam int BCD_W = 4 * DIG_PER_CH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (ND > 1) ? $clog2(ND) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    logic [CH_W-1:0]  ch_sel;
    logic [BIN_W-1:0] cur_score;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_ovf;

    logic [BCD_W-1:0]  disp_bcd_q [NUM_CH];
    logic [NUM_CH-1:0] disp_ovf_q;

    logic [PRE_W-1:0] pre_q;
    logic             pre_tc;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;

    logic [6:0]    dig_seg   [ND];
    logic [ND-1:0] dig_blank;
    logic [ND-1:0] anode_d;
    logic [6:0]    segment_d;

    // Score of the channel currently owning the converter.
    always_comb begin
        cur_score = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_W'(c)) begin
                cur_score = score_i[c*BIN_W +: BIN_W];
            end
        end
    end

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .DIG_PER_CH (DIG_PER_CH)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (~conv_busy),
        .bin   (cur_score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Capture finished conversions and rotate to the next channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_sel     <= '0;
            disp_ovf_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                disp_bcd_q[c] <= '0;
            end
        end else if (conv_done) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == CH_W'(c)) begin
                    disp_bcd_q[c] <= conv_bcd;
                    disp_ovf_q[c] <= conv_ovf;
                end
            end
            ch_sel <= (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + CH_W'(1);
        end
    end

    // Per-digit glyph and blanking, looking through a same-cycle write.
    always_comb begin
        logic [BCD_W-1:0] ch_bcd;
        logic             ch_ovf;
        logic [3:0]       nib;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        logic             seen_nz;
`endif
        dig_blank = '0;
        for (int d = 0; d < ND; d++) begin
            dig_seg[d] = GLYPH_BLANK;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            ch_bcd = (conv_done && ch_sel == CH_W'(c)) ? conv_bcd : disp_bcd_q[c];
            ch_ovf = (conv_done && ch_sel == CH_W'(c)) ? conv_ovf : disp_ovf_q[c];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            seen_nz = 1'b0;
`endif
            for (int k = DIG_PER_CH - 1; k >= 0; k--) begin
                nib = ch_bcd[4*k +: 4];
                dig_seg[c*DIG_PER_CH + k] = ch_ovf ? GLYPH_DASH : glyph(nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                seen_nz = seen_nz | (nib != 4'd0);
                dig_blank[c*DIG_PER_CH + k] = !ch_ovf && !seen_nz && (k != 0);
`endif
            end
        end
    end

    // Scan index after the next terminal count, and the slot it will show.
    always_comb begin
        pre_tc    = (pre_q == PRE_W'(REFRESH_DIV - 1));
        idx_nxt   = (idx_q == IDX_W'(ND - 1)) ? '0 : idx_q + IDX_W'(1);
        anode_d   = '1;
        segment_d = GLYPH_BLANK;
        for (int d = 0; d < ND; d++) begin
            if (idx_nxt == IDX_W'(d) && digit_en_i[d] && !dig_blank[d]) begin
                anode_d   = ~(ND'(1) << d);
                segment_d = dig_seg[d];
            end
        end
    end

    // Refresh prescaler and scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_tc) begin
            pre_q <= '0;
            idx_q <= idx_nxt;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Registered bus outputs, all updated together on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode   <= '1;
            segment <= GLYPH_BLANK;
            frame_o <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (pre_tc) begin
                anode   <= anode_d;
                segment <= segment_d;
                frame_o <= (idx_q == IDX_W'(ND - 1));
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a decimal reference model.
module tb_seg7_scan_driver;

    localparam int NCH   = 2;
    localparam int DPC   = 2;
    localparam int BW    = 9;
    localparam int DIV   = 4;
    localparam int ND    = NCH * DPC;
    localparam int LIMIT = 10 ** DPC;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*BW-1:0] score_i = '0;
    logic [ND-1:0]     digit_en_i = '1;
    logic [ND-1:0]     anode;
    logic [6:0]        segment;
    logic              frame_o;

    int errors = 0;
    int checks = 0;

    int            sc [NCH];
    logic [ND-1:0] en_mask;
    logic [ND-1:0] cap_an  [ND];
    logic [6:0]    cap_seg [ND];
    logic [6:0]    glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_scan_driver #(
        .NUM_CH      (NCH),
        .DIG_PER_CH  (DPC),
        .BIN_W       (BW),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .score_i    (score_i),
        .digit_en_i (digit_en_i),
        .anode      (anode),
        .segment    (segment),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    // Expected segment pattern for decimal digit k of score s.
    function automatic logic [6:0] model_seg(input int s, input int k, input logic en);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (!en) return 7'h7F;
        if (s >= LIMIT) return 7'h3F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k > 0 && s < p) return 7'h7F;
`endif
        return glyph_tab[(s / p) % 10];
    endfunction

    function automatic logic [ND-1:0] model_an(input int s, input int k, input logic en, input int slot);
        logic [ND-1:0] one;
        one = 1;
        return (model_seg(s, k, en) == 7'h7F) ? '1 : ~(one << slot);
    endfunction

    task automatic apply_stim();
        for (int c = 0; c < NCH; c++) score_i[c*BW +: BW] = BW'(sc[c]);
        digit_en_i = en_mask;
    endtask

    task automatic capture_frame(output bit got);
        int n;
        got = 0;
        n = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (frame_o === 1'b1) got = 1;
        end
        if (got) begin
            cap_an[0] = anode;
            cap_seg[0] = segment;
            for (int i = 1; i < ND; i++) begin
                repeat (DIV) @(negedge clk);
                cap_an[i] = anode;
                cap_seg[i] = segment;
            end
        end
    endtask

    task automatic test_reset();
        sc[0] = 37; sc[1] = 0; en_mask = '1;
        apply_stim();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (anode !== 4'hF || segment !== 7'h7F || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold anode=%b seg=%b frame=%b want 1111 1111111 0", anode, segment, frame_o);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            checks++;
            if (anode !== 4'hF || segment !== 7'h7F || frame_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_c%0d anode=%b seg=%b frame=%b want 1111 1111111 0", n, anode, segment, frame_o);
            end
        end
    endtask

    task automatic run_frame_check(input string name);
        bit got;
        logic [6:0] es;
        logic [ND-1:0] ea;
        capture_frame(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_frame no frame_o pulse within 64 cycles", name);
        end else begin
            for (int i = 0; i < ND; i++) begin
                es = model_seg(sc[i / DPC], i % DPC, en_mask[i]);
                ea = model_an(sc[i / DPC], i % DPC, en_mask[i], i);
                checks++;
                if (cap_an[i] !== ea || cap_seg[i] !== es) begin
                    errors++;
                    $display("FAIL %s slot%0d anode=%b seg=%b want anode=%b seg=%b",
                             name, i, cap_an[i], cap_seg[i], ea, es);
                end
            end
        end
    endtask

    task automatic test_basic();
        sc[0] = 37; sc[1] = 0; en_mask = '1;
        apply_stim();
        repeat (50) @(negedge clk);
        run_frame_check("basic_37_0");
    endtask

    task automatic test_overflow();
        sc[1] = 100; apply_stim();
        repeat (50) @(negedge clk);
        run_frame_check("ovf_100");
        sc[1] = 99; apply_stim();
        repeat (50) @(negedge clk);
        run_frame_check("ovf_99");
        sc[1] = 511; sc[0] = 0; apply_stim();
        repeat (50) @(negedge clk);
        run_frame_check("ovf_511_0");
    endtask

    task automatic test_leading_zero();
        sc[0] = 5; sc[1] = 10; en_mask = '1; apply_stim();
        repeat (50) @(negedge clk);
        run_frame_check("lead_zero_5_10");
    endtask

    task automatic test_digit_enable();
        sc[0] = 37; sc[1] = 64; en_mask = 4'b1110; apply_stim();
        repeat (50) @(negedge clk);
        run_frame_check("digit_en_1110");
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            sc[0] = int'($urandom_range(0, (1 << BW) - 1));
            sc[1] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 99))
                                                : int'($urandom_range(0, (1 << BW) - 1));
            en_mask = ($urandom_range(0, 2) == 0) ? ND'($urandom_range(0, 15)) : '1;
            apply_stim();
            repeat (50) @(negedge clk);
            run_frame_check("random");
        end
    endtask

    // Reset-synchronised run: score0 moves 37->42 during channel 0's first shift.
    task automatic test_mid_shift_update();
        logic [6:0] es;
        rst_n = 1'b0;
        sc[0] = 37; sc[1] = 0; en_mask = '1; apply_stim();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 52; n++) begin
            @(negedge clk);
            if (n == 15 || n == 17) begin
                checks++;
                if (frame_o !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_shift_frame_c%0d frame=%b want 0", n, frame_o);
                end
            end
            if (n == 16 || n == 32 || n == 48) begin
                es = (n == 48) ? glyph_tab[2] : glyph_tab[7];
                checks++;
                if (frame_o !== 1'b1 || anode !== 4'b1110 || segment !== es) begin
                    errors++;
                    $display("FAIL mid_shift_slot0_c%0d frame=%b anode=%b seg=%b want 1 1110 %b",
                             n, frame_o, anode, segment, es);
                end
            end
            if (n == 20 || n == 36 || n == 52) begin
                es = (n == 20) ? glyph_tab[3] : glyph_tab[4];
                checks++;
                if (anode !== 4'b1101 || segment !== es) begin
                    errors++;
                    $display("FAIL mid_shift_slot1_c%0d anode=%b seg=%b want 1101 %b", n, anode, segment, es);
                end
            end
            if (n == 4) begin
                checks++;
                if (anode !== model_an(0, 1, 1'b1, 1) || segment !== model_seg(0, 1, 1'b1)) begin
                    errors++;
                    $display("FAIL mid_shift_cleared_c4 anode=%b seg=%b want %b %b",
                             anode, segment, model_an(0, 1, 1'b1, 1), model_seg(0, 1, 1'b1));
                end
                sc[0] = 42; apply_stim();
            end
        end
    endtask

    // Async reset while channel 0 is shifting and slot 1 is lit.
    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if (anode !== 4'hF || segment !== 7'h7F || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async anode=%b seg=%b frame=%b want 1111 1111111 0", anode, segment, frame_o);
        end
        sc[0] = 58; sc[1] = 123; en_mask = '1; apply_stim();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            if (n == 4) begin
                checks++;
                if (anode !== model_an(0, 1, 1'b1, 1) || segment !== model_seg(0, 1, 1'b1)) begin
                    errors++;
                    $display("FAIL reset_mid_cleared anode=%b seg=%b want %b %b",
                             anode, segment, model_an(0, 1, 1'b1, 1), model_seg(0, 1, 1'b1));
                end
            end
            if (n == 16 || n == 20 || n == 24 || n == 28) begin
                int slot;
                slot = (n - 16) / DIV;
                checks++;
                if (anode !== model_an(sc[slot / DPC], slot % DPC, 1'b1, slot) ||
                    segment !== model_seg(sc[slot / DPC], slot % DPC, 1'b1)) begin
                    errors++;
                    $display("FAIL reset_mid_restart slot%0d anode=%b seg=%b want %b %b", slot, anode, segment,
                             model_an(sc[slot / DPC], slot % DPC, 1'b1, slot),
                             model_seg(sc[slot / DPC], slot % DPC, 1'b1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_leading_zero();
        test_digit_enable();
        test_random();
        test_mid_shift_update();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-channel 7-segment scan driver. Converts NUM_CH unsigned binary scores to decimal with a sequential shift-add-3 converter, holds per-channel BCD display registers, and time-multiplexes all digits onto a shared active-low anode/segment bus. Sits between game score registers and the board's 8-digit display, and adds channel/digit generalisation, a refresh prescaler, a digit-enable mask and overflow indication.

## Interface
- NUM_CH, 2: number of score channels.
- DIG_PER_CH, 4: decimal digits per channel; NUM_CH*DIG_PER_CH ≤ 8.
- BIN_W, 9: width of each binary score.
- REFRESH_DIV, 100000: clk cycles per digit slot (≥2).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- score_i  in  NUM_CH*BIN_W  packed scores; channel c = score_i[c*BIN_W +: BIN_W].
- digit_en_i  in  ND (=NUM_CH*DIG_PER_CH)  per-digit enable; 0 forces that digit dark.
- anode  out  ND  one-hot-low digit select; bit 0 is rightmost.
- segment  out  7  active-low {g,f,e,d,c,b,a}.
- frame_o  out  1  one-cycle pulse when scan index wraps to 0.

## Operation
- Digit mapping: channel c, decimal digit k (k=0 least significant) drives anode bit c*DIG_PER_CH+k.
- Converter FSM, round-robin over channels: LOAD (latch score of channel ch_sel, clear BCD shifter and ovf) -> SHIFT (exactly BIN_W cycles: add 3 to every nibble ≥5, then shift left bringing in next MSB; a 1 shifted out of the top nibble sets sticky ovf) -> WRITE (copy DIG_PER_CH nibbles and ovf into channel's display register; ch_sel increments, wraps NUM_CH-1 -> 0) -> LOAD.
- Per-channel refresh period: NUM_CH*(BIN_W+2) cycles. Score changes during SHIFT are taken at that channel's next LOAD.
- ovf=1 iff score ≥ 10^DIG_PER_CH; all of that channel's digits display dash (7'b0111111).
- Scan: prescaler counts 0..REFRESH_DIV-1; on terminal count scan index advances 0..ND-1, wraps to 0 and pulses frame_o.
- Per slot: if digit_en_i[idx]=0 or digit blanked -> anode all ones, segment 7'h7F; else anode bit idx low, segment = glyph of nibble.
- Glyphs: 0..9 standard (0=7'b1000000, 3=7'b0110000, 7=7'b1111000); nibbles 10..15 cannot occur and display blank.

## Timing
- Reset: anode all ones, segment 7'h7F, frame_o 0, prescaler 0, scan index 0, display registers 0, ovf 0, FSM LOAD, ch_sel 0.
- anode, segment, frame_o registered; change the cycle after prescaler terminal count, all three aligned.
- First valid value for channel c visible in display register c*(BIN_W+2)+BIN_W+2 cycles after reset release.
- Display register write and glyph lookup in the same cycle as a scan advance: scan uses the newly written value (write-first).
- Reset asserted mid-conversion or mid-slot: immediate return to reset values; no partial display register update.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: within a non-overflowed channel, zero digits above the most significant non-zero digit are blanked; digit 0 always shown (value 0 shows "0").
- Undefined: all digits shown, leading zeros displayed as "0".

## Structure
- Shared package seg7_pkg: glyph constants (digits 0-9, dash, blank), glyph function, FSM state encoding.
- Sub-module bin2bcd_seq: sequential double-dabble, parameters BIN_W/DIG_PER_CH, start/busy/done handshake, bcd and ovf outputs. Top owns channel arbitration, display registers, prescaler and scan.

## Test plan
- NUM_CH=2, DIG_PER_CH=2, BIN_W=9, REFRESH_DIV=4, score0=37, score1=0 -> bit0 slot segment 7'b1111000, bit1 slot 7'b0110000, frame_o every 16 cycles.
- score1=100 -> anode bits 2,3 show 7'b0111111; score1=99 then shows "99".
- score0=5 with SEG7_LEADING_ZERO_BLANK_EN -> bit1 slot anode all ones; without macro -> bit1 shows 7'b1000000.
- digit_en_i=4'b1110, score0=37 -> bit0 slot anode 4'hF, segment 7'h7F; other digits unaffected.
- score0 changes 37->42 mid-SHIFT -> display keeps "37" until next channel-0 WRITE, then "42".
- rst_n low mid-SHIFT and mid-slot -> anode 4'hF, segment 7'h7F same cycle; after release conversion restarts at channel 0.
